// File: rtl/handshake_master.sv
// Valid/ready source stage: a DEPTH-entry FIFO feeding one output register.
// Data written by the local producer leaves in write order; the total capacity is DEPTH+1 words.
module handshake_master #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             overflow,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready,
    output logic [AW+1:0]    level,
    output logic [15:0]      tx_cnt
);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fifo_cnt;
    logic             xfer;
    logic             push;
    logic             pop;

    assign valid = (state == HOLD);
    assign xfer  = valid && ready;
    assign full  = (fifo_cnt == (AW+1)'(DEPTH));
    assign level = {1'b0, fifo_cnt} + (AW+2)'(valid);
    assign pop   = xfer && (fifo_cnt != '0);
    // A write goes to the FIFO only when the output register cannot take it directly.
    assign push  = wr_en && !full && valid && !(ready && (fifo_cnt == '0));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            data_out <= '0;
            overflow <= 1'b0;
            tx_cnt   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                tx_cnt <= tx_cnt + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + (AW+1)'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - (AW+1)'(1);
            end
            // The FIFO is always empty in EMPTY, so a write there can never be dropped.
            case (state)
                EMPTY: begin
                    if (wr_en) begin
                        data_out <= wr_data;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        if (pop) begin
                            data_out <= mem[rd_ptr];
                        end else if (wr_en) begin
                            data_out <= wr_data;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
